// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack memory/boot controller.
// No logic; imported by the loader and the top.
// Boot states, default IO base address and IO channel indices.
package hack_pkg;

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CSUM_HI = 3'd4,
        CSUM_LO = 3'd5,
        RUN     = 3'd6,
        ERR     = 3'd7
    } boot_state_e;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'h4000;

    localparam int IO_LCD = 0;
    localparam int IO_RX  = 1;
    localparam int IO_TX  = 2;

    // Big-endian byte pair to word.
    function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/hack_mem_boot_ctrl_if.sv
// Boot byte stream, CPU instruction/data bus and IO channel bus bundle.
// No logic; signal names mirror the controller's i_/o_ ports.
// slave = controller side, master = CPU/UART/peripheral side.
interface hack_mem_boot_ctrl_if #(
    parameter int NUM_IO = 3
);
    logic [7:0]           i_rx_byte;
    logic                 i_rx_valid;
    logic                 o_rx_ready;
    logic [15:0]          i_pc;
    logic [15:0]          o_instruction;
    logic [15:0]          i_ramaddr;
    logic [15:0]          i_ram_wdata;
    logic                 i_ram_write;
    logic [15:0]          o_ram_rdata;
    logic [NUM_IO-1:0]    o_io_sel;
    logic [15:0]          o_io_wdata;
    logic                 o_io_write;
    logic [16*NUM_IO-1:0] i_io_rdata;

    modport slave (
        input  i_rx_byte, i_rx_valid, i_pc, i_ramaddr, i_ram_wdata, i_ram_write, i_io_rdata,
        output o_rx_ready, o_instruction, o_ram_rdata, o_io_sel, o_io_wdata, o_io_write
    );

    modport master (
        output i_rx_byte, i_rx_valid, i_pc, i_ramaddr, i_ram_wdata, i_ram_write, i_io_rdata,
        input  o_rx_ready, o_instruction, o_ram_rdata, o_io_sel, o_io_wdata, o_io_write
    );
endinterface

// File: rtl/hack_boot_loader.sv
// Boot loader FSM: parses LEN/DATA/CSUM byte stream and drives the ROM write port.
// ROM write is combinational on the accepted DATA_LO byte; state outputs are registered.
// o_rx_ready high in every load state, low in RUN and ERR.
module hack_boot_loader
    import hack_pkg::*;
#(
    parameter int  ROM_DEPTH = 1024,
    localparam int AW_ROM    = $clog2(ROM_DEPTH)
) (
    input  logic              CLK,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    input  logic              i_boot_req,
    output logic              o_rom_we,
    output logic [AW_ROM-1:0] o_rom_waddr,
    output logic [15:0]       o_rom_wdata,
    output logic              o_run,
    output logic              o_boot_err,
    output logic [15:0]       o_words_loaded
);

    localparam logic [2:0] ST_LEN_HI  = LEN_HI;
    localparam logic [2:0] ST_LEN_LO  = LEN_LO;
    localparam logic [2:0] ST_DATA_HI = DATA_HI;
    localparam logic [2:0] ST_DATA_LO = DATA_LO;
    localparam logic [2:0] ST_CSUM_HI = CSUM_HI;
    localparam logic [2:0] ST_CSUM_LO = CSUM_LO;
    localparam logic [2:0] ST_RUN     = RUN;
    localparam logic [2:0] ST_ERR     = ERR;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_hi;
    logic [15:0] r_len;
    logic [15:0] r_words;
    logic [15:0] r_sum;

    logic        w_rdy;
    logic        w_accept;
    logic        w_done;
    logic [15:0] w_word;
    logic [15:0] w_words_nxt;
    logic        w_len_big;

    assign w_done      = (r_state == ST_RUN) || (r_state == ST_ERR);
    assign w_rdy       = ~w_done;
    assign w_accept    = i_rx_valid & w_rdy;
    assign w_word      = be_word(r_hi, i_rx_byte);
    assign w_words_nxt = r_words + 16'd1;
    assign w_len_big   = 32'(w_word) > ROM_DEPTH;

    // Next state: load states advance only on an accepted byte; RUN/ERR leave only on boot request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LEN_HI:  if (w_accept) w_state_nxt = ST_LEN_LO;
            ST_LEN_LO:  if (w_accept) begin
                            if (w_word == 16'd0)  w_state_nxt = ST_CSUM_HI;
                            else if (w_len_big)   w_state_nxt = ST_ERR;
                            else                  w_state_nxt = ST_DATA_HI;
                        end
            ST_DATA_HI: if (w_accept) w_state_nxt = ST_DATA_LO;
            ST_DATA_LO: if (w_accept) w_state_nxt = (w_words_nxt == r_len) ? ST_CSUM_HI : ST_DATA_HI;
            ST_CSUM_HI: if (w_accept) w_state_nxt = ST_CSUM_LO;
            ST_CSUM_LO: if (w_accept) w_state_nxt = (w_word == r_sum) ? ST_RUN : ST_ERR;
            ST_RUN,
            ST_ERR:     if (i_boot_req) w_state_nxt = ST_LEN_HI;
            default:    w_state_nxt = ST_LEN_HI;
        endcase
    end

    // State, byte holding register, length, word count and running checksum.
    always_ff @(posedge CLK) begin
        if (i_reset) begin
            r_state <= ST_LEN_HI;
            r_hi    <= 8'd0;
            r_len   <= 16'd0;
            r_words <= 16'd0;
            r_sum   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                case (r_state)
                    ST_LEN_HI, ST_DATA_HI, ST_CSUM_HI: r_hi <= i_rx_byte;
                    ST_LEN_LO:  r_len <= w_word;
                    ST_DATA_LO: begin
                        r_words <= w_words_nxt;
                        r_sum   <= r_sum + w_word;
                    end
                    default: ;
                endcase
            end
            if (w_done && i_boot_req) begin
                r_words <= 16'd0;
                r_sum   <= 16'd0;
            end
        end
    end

    // The word count never exceeds the accepted length, so it always indexes inside the ROM.
    assign o_rom_we       = w_accept & (r_state == ST_DATA_LO) & ~i_reset;
    assign o_rom_waddr    = r_words[AW_ROM-1:0];
    assign o_rom_wdata    = w_word;
    assign o_rx_ready     = w_rdy;
    assign o_run          = (r_state == ST_RUN);
    assign o_boot_err     = (r_state == ST_ERR);
    assign o_words_loaded = r_words;

endmodule

// File: rtl/hack_mem_boot_ctrl.sv
// Hack memory/boot controller: ROM+RAM arrays, byte-stream ROM loader, CPU reset, IO decode.
// Instruction and data reads are registered (1 cycle); IO select/write are combinational.
// Boot bytes accepted only while loading; CPU writes ignored outside RUN.
module hack_mem_boot_ctrl
    import hack_pkg::*;
#(
    parameter int          ROM_DEPTH = 1024,
    parameter int          RAM_DEPTH = 1024,
    parameter int          NUM_IO    = 3,
    parameter logic [15:0] IO_BASE   = IO_BASE_DEFAULT,
    localparam int         AW_ROM    = $clog2(ROM_DEPTH),
    localparam int         AW_RAM    = $clog2(RAM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  i_reset,
    input  logic                  i_boot_req,
    hack_mem_boot_ctrl_if.slave   bus,
    output logic                  o_cpu_reset,
    output logic                  o_mode,
    output logic                  o_boot_err,
    output logic [15:0]           o_words_loaded
);

    logic [15:0] r_rom [ROM_DEPTH];
    logic [15:0] r_ram [RAM_DEPTH];
    logic [15:0] r_instr;
    logic [15:0] r_rdata;

    logic              w_run;
    logic              w_rom_we;
    logic [AW_ROM-1:0] w_rom_waddr;
    logic [15:0]       w_rom_wdata;
    logic [NUM_IO-1:0] w_io_sel;
    logic              w_io_hit;
    logic [15:0]       w_io_rdata;
    logic              w_pc_in_rom;
    logic              w_addr_in_ram;
    logic              w_ram_we;
    logic [15:0]       w_instr_nxt;
    logic [15:0]       w_rdata_nxt;

    hack_boot_loader #(
        .ROM_DEPTH (ROM_DEPTH)
    ) u_loader (
        .CLK            (CLK),
        .i_reset        (i_reset),
        .i_rx_byte      (bus.i_rx_byte),
        .i_rx_valid     (bus.i_rx_valid),
        .o_rx_ready     (bus.o_rx_ready),
        .i_boot_req     (i_boot_req),
        .o_rom_we       (w_rom_we),
        .o_rom_waddr    (w_rom_waddr),
        .o_rom_wdata    (w_rom_wdata),
        .o_run          (w_run),
        .o_boot_err     (o_boot_err),
        .o_words_loaded (o_words_loaded)
    );

    // Exact 16-bit match per channel, so at most one select bit is ever set.
    for (genvar k = 0; k < NUM_IO; k++) begin : g_io_dec
        localparam logic [15:0] CH_ADDR = IO_BASE + 16'(k);
        assign w_io_sel[k] = (bus.i_ramaddr == CH_ADDR);
    end

    assign w_io_hit = |w_io_sel;

    // Read data of the selected IO channel (zero when no channel is addressed).
    always_comb begin
        w_io_rdata = 16'd0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (w_io_sel[k]) w_io_rdata = w_io_rdata | bus.i_io_rdata[16*k +: 16];
        end
    end

    assign w_pc_in_rom   = 32'(bus.i_pc) < ROM_DEPTH;
    assign w_addr_in_ram = 32'(bus.i_ramaddr) < RAM_DEPTH;
    assign w_instr_nxt   = w_pc_in_rom ? r_rom[bus.i_pc[AW_ROM-1:0]] : 16'd0;
    assign w_rdata_nxt   = w_io_hit      ? w_io_rdata :
                           w_addr_in_ram ? r_ram[bus.i_ramaddr[AW_RAM-1:0]] : 16'd0;
    // IO takes priority over RAM if a channel ever overlaps the RAM range.
    assign w_ram_we      = w_run & bus.i_ram_write & ~w_io_hit & w_addr_in_ram & ~i_reset;

    // ROM array: written only by the boot loader.
    always_ff @(posedge CLK) begin
        if (w_rom_we) r_rom[w_rom_waddr] <= w_rom_wdata;
    end

    // RAM array: CPU writes while running.
    always_ff @(posedge CLK) begin
        if (w_ram_we) r_ram[bus.i_ramaddr[AW_RAM-1:0]] <= bus.i_ram_wdata;
    end

    // Registered instruction and data read ports; reads see the pre-write array contents.
    always_ff @(posedge CLK) begin
        if (i_reset) begin
            r_instr <= 16'd0;
            r_rdata <= 16'd0;
        end else begin
            r_instr <= w_instr_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign bus.o_instruction = r_instr;
    assign bus.o_ram_rdata   = r_rdata;
    assign bus.o_io_sel      = w_io_sel;
    assign bus.o_io_wdata    = bus.i_ram_wdata;
    assign bus.o_io_write    = bus.i_ram_write & w_io_hit & w_run;
    assign o_mode            = w_run;
    assign o_cpu_reset       = ~w_run;

endmodule

// File: tb/tb_hack_mem_boot_ctrl.sv
// Randomized bench for hack_mem_boot_ctrl with a byte-position based reference model.
module tb_hack_mem_boot_ctrl;

    localparam int          ROM_DEPTH = 64;
    localparam int          RAM_DEPTH = 128;
    localparam int          NUM_IO    = 3;
    localparam logic [15:0] IO_BASE   = 16'h4000;
    localparam int          IOW       = 16 * NUM_IO;
    localparam int          M_LOAD = 0, M_RUN = 1, M_ERR = 2;

    logic CLK = 1'b0;
    logic i_reset, i_boot_req;
    logic o_cpu_reset, o_mode, o_boot_err;
    logic [15:0] o_words_loaded;

    hack_mem_boot_ctrl_if #(.NUM_IO(NUM_IO)) bus ();

    hack_mem_boot_ctrl #(
        .ROM_DEPTH (ROM_DEPTH),
        .RAM_DEPTH (RAM_DEPTH),
        .NUM_IO    (NUM_IO),
        .IO_BASE   (IO_BASE)
    ) dut (
        .CLK            (CLK),
        .i_reset        (i_reset),
        .i_boot_req     (i_boot_req),
        .bus            (bus),
        .o_cpu_reset    (o_cpu_reset),
        .o_mode         (o_mode),
        .o_boot_err     (o_boot_err),
        .o_words_loaded (o_words_loaded)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The load is tracked purely by how many bytes have been accepted since it began.
    bit          m_init = 0;
    int          m_mode = M_LOAD;
    int          m_pos  = 0;
    int          m_len  = 0;
    logic [7:0]  m_bytes [0:511];
    logic [15:0] m_rom   [0:ROM_DEPTH-1];
    bit          m_rom_k [0:ROM_DEPTH-1];
    logic [15:0] m_ram   [0:RAM_DEPTH-1];
    bit          m_ram_k [0:RAM_DEPTH-1];
    logic [15:0] e_instr, e_rdata;
    bit          e_instr_v = 0, e_rdata_v = 0;

    function automatic int io_index(input logic [15:0] a);
        return int'(a) - int'(IO_BASE);
    endfunction

    function automatic bit io_hit(input logic [15:0] a);
        int k = io_index(a);
        return (k >= 0) && (k < NUM_IO);
    endfunction

    function automatic int exp_words();
        int w;
        if (m_pos <= 2) return 0;
        w = (m_pos - 2) / 2;
        return (w < m_len) ? w : m_len;
    endfunction

    task automatic accept_byte(input logic [7:0] b);
        int j;
        logic [15:0] s, cs;
        m_bytes[m_pos] = b;
        m_pos++;
        if (m_pos == 2) begin
            m_len = int'({m_bytes[0], m_bytes[1]});
            if (m_len > ROM_DEPTH) m_mode = M_ERR;
        end else if (m_pos > 2 && m_pos <= 2 + 2*m_len && (m_pos % 2) == 0) begin
            j = (m_pos - 2) / 2 - 1;
            m_rom[j]   = {m_bytes[m_pos-2], m_bytes[m_pos-1]};
            m_rom_k[j] = 1;
        end else if (m_pos == 4 + 2*m_len) begin
            s = 16'd0;
            for (int i = 0; i < m_len; i++) s = s + {m_bytes[2+2*i], m_bytes[3+2*i]};
            cs = {m_bytes[m_pos-2], m_bytes[m_pos-1]};
            m_mode = (cs == s) ? M_RUN : M_ERR;
        end
    endtask

    task automatic model_step();
        int k;
        if (i_reset) begin
            m_init = 1; m_mode = M_LOAD; m_pos = 0;
            e_instr = 16'd0; e_instr_v = 1;
            e_rdata = 16'd0; e_rdata_v = 1;
        end else begin
            if (int'(bus.i_pc) < ROM_DEPTH) begin
                e_instr_v = m_rom_k[bus.i_pc];
                e_instr   = m_rom[bus.i_pc];
            end else begin
                e_instr_v = 1; e_instr = 16'd0;
            end
            if (io_hit(bus.i_ramaddr)) begin
                k = io_index(bus.i_ramaddr);
                e_rdata = bus.i_io_rdata[16*k +: 16]; e_rdata_v = 1;
            end else if (int'(bus.i_ramaddr) < RAM_DEPTH) begin
                e_rdata = m_ram[bus.i_ramaddr]; e_rdata_v = m_ram_k[bus.i_ramaddr];
            end else begin
                e_rdata = 16'd0; e_rdata_v = 1;
            end
            if (m_mode == M_RUN && bus.i_ram_write && !io_hit(bus.i_ramaddr)
                && int'(bus.i_ramaddr) < RAM_DEPTH) begin
                m_ram[bus.i_ramaddr]   = bus.i_ram_wdata;
                m_ram_k[bus.i_ramaddr] = 1;
            end
            if (m_mode != M_LOAD) begin
                if (i_boot_req) begin m_mode = M_LOAD; m_pos = 0; end
            end else if (bus.i_rx_valid) begin
                accept_byte(bus.i_rx_byte);
            end
        end
    endtask

    task automatic compare();
        logic [NUM_IO-1:0] sel;
        sel = '0;
        if (io_hit(bus.i_ramaddr)) sel[io_index(bus.i_ramaddr)] = 1'b1;
        chk("rx_ready",     32'(bus.o_rx_ready), 32'(m_mode == M_LOAD));
        chk("mode",         32'(o_mode),         32'(m_mode == M_RUN));
        chk("cpu_reset",    32'(o_cpu_reset),    32'(m_mode != M_RUN));
        chk("boot_err",     32'(o_boot_err),     32'(m_mode == M_ERR));
        chk("words_loaded", 32'(o_words_loaded), 32'(exp_words()));
        if (e_instr_v) chk("instruction", 32'(bus.o_instruction), 32'(e_instr));
        if (e_rdata_v) chk("ram_rdata",   32'(bus.o_ram_rdata),   32'(e_rdata));
        chk("io_sel",   32'(bus.o_io_sel),   32'(sel));
        chk("io_write", 32'(bus.o_io_write), 32'(bus.i_ram_write && io_hit(bus.i_ramaddr) && m_mode == M_RUN));
        chk("io_wdata", 32'(bus.o_io_wdata), 32'(bus.i_ram_wdata));
    endtask

    // Model advances on each edge; DUT outputs are compared 1 time unit later.
    initial begin
        forever begin
            @(posedge CLK);
            model_step();
            #1;
            if (m_init) compare();
        end
    end

    // ---------------- stimulus ----------------
    bit cpu_rand = 0;
    logic [7:0] stream [$];

    initial begin
        forever begin
            @(negedge CLK);
            if (cpu_rand) begin
                case ($urandom_range(0, 3))
                    0, 1:    bus.i_pc = 16'($urandom_range(0, 15));
                    2:       bus.i_pc = 16'(ROM_DEPTH - 1 + $urandom_range(0, 1));
                    default: bus.i_pc = 16'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0:       bus.i_ramaddr = IO_BASE + 16'($urandom_range(0, NUM_IO));
                    1:       bus.i_ramaddr = IO_BASE - 16'd1;
                    2, 3:    bus.i_ramaddr = 16'($urandom_range(0, 7));
                    4:       bus.i_ramaddr = 16'(RAM_DEPTH - 1 + $urandom_range(0, 1));
                    default: bus.i_ramaddr = 16'($urandom);
                endcase
                bus.i_ram_wdata = 16'($urandom);
                bus.i_ram_write = 1'($urandom_range(0, 1));
                bus.i_io_rdata  = IOW'({$urandom, $urandom});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        @(negedge CLK);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_byte  = b;
        // A boot request during loading must be ignored.
        if (bus.o_rx_ready && $urandom_range(0, 7) == 0) i_boot_req = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (bus.o_rx_ready) ok = 1;
            @(negedge CLK);
            i_boot_req = 1'b0;
        end
        bus.i_rx_valid = 1'b0;
        bus.i_rx_byte  = 8'($urandom);
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic send_stream(input int count);
        for (int i = 0; i < count && i < stream.size(); i++) send_byte(stream[i]);
    endtask

    task automatic build_stream(input int n, input bit good);
        logic [15:0] s = 16'd0;
        logic [15:0] w;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            s = s + w;
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
        end
        if (!good) s = s + 16'd1;
        stream.push_back(s[15:8]);
        stream.push_back(s[7:0]);
    endtask

    task automatic pulse_boot_req();
        @(negedge CLK); i_boot_req = 1'b1;
        @(negedge CLK); i_boot_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK); i_reset = 1'b1; bus.i_rx_valid = 1'b0;
        @(negedge CLK); i_reset = 1'b0;
    endtask

    task automatic cpu_hold();
        cpu_rand = 0;
        @(negedge CLK);
        bus.i_ram_write = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, actual running required done");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_boot_req = 1'b0;
        bus.i_rx_valid = 1'b0; bus.i_rx_byte = 8'd0;
        bus.i_pc = 16'd0; bus.i_ramaddr = 16'd0; bus.i_ram_wdata = 16'd0;
        bus.i_ram_write = 1'b0; bus.i_io_rdata = '0;
        repeat (3) @(negedge CLK);
        chk("rst_rx_ready",  32'(bus.o_rx_ready),    32'd1);
        chk("rst_mode",      32'(o_mode),            32'd0);
        chk("rst_cpu_reset", 32'(o_cpu_reset),       32'd1);
        chk("rst_words",     32'(o_words_loaded),    32'd0);
        chk("rst_instr",     32'(bus.o_instruction), 32'd0);
        chk("rst_rdata",     32'(bus.o_ram_rdata),   32'd0);
        i_reset = 1'b0;
        cpu_rand = 1;

        // Two-word load with matching checksum.
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        send_stream(8);
        chk("t1_mode",      32'(o_mode),         32'd1);
        chk("t1_cpu_reset", 32'(o_cpu_reset),    32'd0);
        chk("t1_words",     32'(o_words_loaded), 32'd2);
        cpu_hold();
        bus.i_pc = 16'(ROM_DEPTH);
        @(negedge CLK); chk("t5_pc_oob", 32'(bus.o_instruction), 32'd0);
        bus.i_pc = 16'd1;
        @(negedge CLK); chk("t5_rom1", 32'(bus.o_instruction), 32'h0000ABCD);
        bus.i_pc = 16'd0;
        @(negedge CLK); chk("t1_rom0", 32'(bus.o_instruction), 32'h00001234);

        // IO read and write while running.
        bus.i_io_rdata = IOW'(48'h3333_2222_1111);
        bus.i_ramaddr  = 16'h4001;
        @(negedge CLK); chk("t4_io_read", 32'(bus.o_ram_rdata), 32'h00002222);
        bus.i_ramaddr = 16'h0000; bus.i_ram_wdata = 16'h5A5A; bus.i_ram_write = 1'b1;
        @(negedge CLK);
        bus.i_ramaddr = 16'h4000; bus.i_ram_wdata = 16'hFFFF;
        #1;
        chk("t4_io_write", 32'(bus.o_io_write), 32'd1);
        chk("t4_io_sel",   32'(bus.o_io_sel),   32'b001);
        @(negedge CLK);
        bus.i_ram_write = 1'b0; bus.i_ramaddr = 16'h0000;
        @(negedge CLK); chk("t4_ram0_kept", 32'(bus.o_ram_rdata), 32'h00005A5A);
        cpu_rand = 1;

        // Checksum mismatch, then recovery by boot request.
        pulse_boot_req();
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
        send_stream(8);
        chk("t2_err",       32'(o_boot_err),     32'd1);
        chk("t2_rx_ready",  32'(bus.o_rx_ready), 32'd0);
        chk("t2_cpu_reset", 32'(o_cpu_reset),    32'd1);
        pulse_boot_req();
        chk("t2_err_clr",   32'(o_boot_err),     32'd0);
        chk("t2_words_clr", 32'(o_words_loaded), 32'd0);

        // Length one past the ROM size.
        stream = '{8'h00, 8'(ROM_DEPTH + 1)};
        send_stream(2);
        chk("t3_err",   32'(o_boot_err),     32'd1);
        chk("t3_words", 32'(o_words_loaded), 32'd0);
        @(negedge CLK); bus.i_rx_valid = 1'b1; bus.i_rx_byte = 8'h55;
        repeat (3) @(negedge CLK);
        bus.i_rx_valid = 1'b0;
        pulse_boot_req();

        // Length exactly equal to the ROM size is legal.
        build_stream(ROM_DEPTH, 1'b1);
        send_stream(stream.size());
        chk("full_rom_mode",  32'(o_mode),         32'd1);
        chk("full_rom_words", 32'(o_words_loaded), 32'(ROM_DEPTH));
        pulse_boot_req();

        // Reset in the middle of a three-word load, then an empty load.
        stream = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        send_stream(6);
        do_reset();
        chk("t6_words", 32'(o_words_loaded), 32'd0);
        chk("t6_ready", 32'(bus.o_rx_ready), 32'd1);
        stream = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(4);
        chk("t6_run", 32'(o_mode), 32'd1);
        cpu_hold();
        bus.i_pc = 16'd1;
        @(negedge CLK); chk("t6_rom1_kept", 32'(bus.o_instruction), 32'h00002222);
        cpu_rand = 1;

        // Randomized loads.
        for (int it = 0; it < 25; it++) begin
            int r;
            if (!bus.o_rx_ready) pulse_boot_req();
            r = $urandom_range(0, 9);
            if (r == 0) begin
                stream = '{8'h00, 8'(ROM_DEPTH + $urandom_range(1, 3))};
                send_stream(2);
            end else begin
                build_stream($urandom_range(0, 12), $urandom_range(0, 3) != 0);
                if (r == 1) begin
                    send_stream($urandom_range(1, stream.size() - 1));
                    do_reset();
                end else begin
                    send_stream(stream.size());
                end
            end
            repeat ($urandom_range(5, 20)) @(negedge CLK);
        end

        cpu_rand = 0;
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
